// File: rtl/proc_sequencer.sv
// Instruction sequencer for the 4-register datapath: queues 10-bit instruction words in a FIFO
// and issues each one as a 1- or 3-step Moore-decoded control sequence.
module proc_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [CW-1:0] instr_count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          data_out,
  output logic [3:0]    R_in,
  output logic [3:0]    R_out,
  output logic          AddSub,
  output logic          Rh_in,
  output logic          Rl_in,
  output logic          Rl_out,
  output logic          AS_enable,
  output logic          XOR_enable,
  output logic [1:0]    sel
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StS1, StS2, StS3} state_e;

  state_e          state_q, state_d;
  logic [9:0]      ir_q, ir_d;
  logic [9:0]      mem_q [DEPTH];
  logic [9:0]      mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;

  logic [3:0] func;
  logic [2:0] rx, ry;
  logic       is_load, is_move, is_add, is_sub, is_xor, is_alu;
  logic       illegal, three_step, last_step;

  function automatic logic [3:0] onehot(input logic [2:0] n);
    return 4'b0001 << n[1:0];
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = instr_valid & ~full;

  assign func = ir_q[9:6];
  assign rx   = ir_q[5:3];
  assign ry   = ir_q[2:0];

  assign is_load = (func == 4'b0001);
  assign is_move = (func == 4'b0010);
  assign is_add  = (func == 4'b0011);
  assign is_sub  = (func == 4'b0100);
  assign is_xor  = (func == 4'b0101);
  assign is_alu  = is_add | is_sub | is_xor;

  // Only operands the instruction actually uses can make it illegal.
  assign illegal    = (is_load & rx[2]) | ((is_move | is_alu) & (rx[2] | ry[2]));
  assign three_step = is_alu & ~illegal;
  assign last_step  = (state_q == StIdle) | (state_q == StS3) |
                      ((state_q == StS1) & ~three_step);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pop     = 1'b0;
    if (last_step) begin
      if (!empty) begin
        pop     = 1'b1;
        ir_d    = mem_q[rptr_q];
        state_d = StS1;
      end else begin
        state_d = StIdle;
      end
    end else if (state_q == StS1) begin
      state_d = StS2;
    end else begin
      state_d = StS3;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = instr;
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ir_q    <= '0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign instr_ready = ~full;
  assign instr_count = count_q;
  assign busy        = (state_q != StIdle);

  always_comb begin
    done       = 1'b0;
    err        = 1'b0;
    data_out   = 1'b0;
    R_in       = '0;
    R_out      = '0;
    AddSub     = 1'b0;
    Rh_in      = 1'b0;
    Rl_in      = 1'b0;
    Rl_out     = 1'b0;
    AS_enable  = 1'b0;
    XOR_enable = 1'b0;
    sel        = 2'b00;
    unique case (state_q)
      StIdle: ;
      StS1: begin
        if (illegal) begin
          err  = 1'b1;
          done = 1'b1;
        end else if (is_load) begin
          data_out = 1'b1;
          R_in     = onehot(rx);
          done     = 1'b1;
        end else if (is_move) begin
          R_in  = onehot(rx);
          R_out = onehot(ry);
          done  = 1'b1;
        end else if (is_alu) begin
          R_out = onehot(rx);
          Rh_in = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      StS2: begin
        R_out = onehot(ry);
        Rl_in = 1'b1;
      end
      StS3: begin
        Rl_out = 1'b1;
        R_in   = onehot(rx);
        done   = 1'b1;
      end
    endcase
    // ALU mode lines are held across all three steps of a legal ALU op.
    if ((state_q != StIdle) && three_step) begin
      AddSub     = is_sub;
      AS_enable  = is_add | is_sub;
      XOR_enable = is_xor;
      sel        = is_sub ? 2'b01 : (is_xor ? 2'b10 : 2'b00);
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: drives instruction words and compares every control
// cycle against hand-computed vectors.
module tb_proc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_count;
  logic       busy, done, err, data_out;
  logic [3:0] R_in, R_out;
  logic       AddSub, Rh_in, Rl_in, Rl_out, AS_enable, XOR_enable;
  logic [1:0] sel;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  proc_sequencer #(.DEPTH(4), .CW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_count(instr_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .data_out   (data_out),
    .R_in       (R_in),
    .R_out      (R_out),
    .AddSub     (AddSub),
    .Rh_in      (Rh_in),
    .Rl_in      (Rl_in),
    .Rl_out     (Rl_out),
    .AS_enable  (AS_enable),
    .XOR_enable (XOR_enable),
    .sel        (sel)
  );

  // {data_out, R_in, R_out, AddSub, Rh_in, Rl_in, Rl_out, AS_enable, XOR_enable, sel, done, err}
  logic [18:0] obs_ctl;
  assign obs_ctl = {data_out, R_in, R_out, AddSub, Rh_in, Rl_in, Rl_out, AS_enable,
                    XOR_enable, sel, done, err};

  function automatic logic [18:0] mk(input logic d, input logic [3:0] ri, input logic [3:0] ro,
                                     input logic as_, input logic rh, input logic rl,
                                     input logic rlo, input logic ase, input logic xe,
                                     input logic [1:0] s, input logic dn, input logic er);
    return {d, ri, ro, as_, rh, rl, rlo, ase, xe, s, dn, er};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  logic [18:0] idle_v;
  logic [18:0] exp6 [6];

  initial begin
    idle_v = '0;

    // Reset state
    #7;
    check("rst_ctl", 32'(obs_ctl), 32'(idle_v));
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // LOAD r2
    push(10'b0001_010_000);
    check("load_count", 32'(instr_count), 32'd1);
    check("load_busy0", 32'(busy), 32'd0);
    tick();
    check("load_s1", 32'(obs_ctl), 32'(mk(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0)));
    check("load_busy1", 32'(busy), 32'd1);
    tick();
    check("load_idle", 32'(obs_ctl), 32'(idle_v));
    check("load_busy2", 32'(busy), 32'd0);

    // ADD r1,r3
    push(10'b0011_001_011);
    tick();
    check("add_s1", 32'(obs_ctl), 32'(mk(0, 0, 4'b0010, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0)));
    tick();
    check("add_s2", 32'(obs_ctl), 32'(mk(0, 0, 4'b1000, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0)));
    tick();
    check("add_s3", 32'(obs_ctl), 32'(mk(0, 4'b0010, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0)));
    tick();
    check("add_idle", 32'(obs_ctl), 32'(idle_v));

    // SUB r0,r1 then XOR r2,r0 back-to-back
    exp6[0] = mk(0, 0, 4'b0001, 1, 1, 0, 0, 1, 0, 2'b01, 0, 0);
    exp6[1] = mk(0, 0, 4'b0010, 1, 0, 1, 0, 1, 0, 2'b01, 0, 0);
    exp6[2] = mk(0, 4'b0001, 0, 1, 0, 0, 1, 1, 0, 2'b01, 1, 0);
    exp6[3] = mk(0, 0, 4'b0100, 0, 1, 0, 0, 0, 1, 2'b10, 0, 0);
    exp6[4] = mk(0, 0, 4'b0001, 0, 0, 1, 0, 0, 1, 2'b10, 0, 0);
    exp6[5] = mk(0, 4'b0100, 0, 0, 0, 0, 1, 0, 1, 2'b10, 1, 0);
    push(10'b0100_000_001);
    push(10'b0101_010_000);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("subxor_c%0d", i + 1), 32'(obs_ctl), 32'(exp6[i]));
      tick();
    end
    check("subxor_idle", 32'(obs_ctl), 32'(idle_v));

    // Fill FIFO behind two ADDs; fifth MOVE must be dropped
    push(10'b0011_000_001);
    push(10'b0011_010_011);
    push(10'b0010_000_001);
    push(10'b0010_001_010);
    push(10'b0010_010_011);
    push(10'b0010_011_011);
    check("full_count", 32'(instr_count), 32'd4);
    check("full_ready", 32'(instr_ready), 32'd0);
    push(10'b0010_000_000);
    check("full_count2", 32'(instr_count), 32'd4);
    check("full_add_s3", 32'(obs_ctl), 32'(mk(0, 4'b0100, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0)));
    tick();
    check("drain_m1", 32'(obs_ctl), 32'(mk(0, 4'b0001, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    check("drain_cnt1", 32'(instr_count), 32'd3);
    tick();
    check("drain_m2", 32'(obs_ctl), 32'(mk(0, 4'b0010, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    tick();
    check("drain_m3", 32'(obs_ctl), 32'(mk(0, 4'b0100, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    tick();
    check("drain_m4", 32'(obs_ctl), 32'(mk(0, 4'b1000, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    check("drain_cnt0", 32'(instr_count), 32'd0);
    tick();
    check("drain_idle", 32'(obs_ctl), 32'(idle_v));
    check("drain_busy", 32'(busy), 32'd0);

    // Illegal MOVE r5,r0 then LOAD r0
    push(10'b0010_101_000);
    tick();
    check("ill_move", 32'(obs_ctl), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    push(10'b0001_000_000);
    tick();
    check("ill_load", 32'(obs_ctl), 32'(mk(1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0)));
    tick();

    // Illegal ADD r0,r4 ends after one step
    push(10'b0011_000_100);
    tick();
    check("ill_add", 32'(obs_ctl), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    tick();
    check("ill_add_end", 32'(busy), 32'd0);

    // NOP with high operand bits: done only, no err
    push(10'b0110_011_111);
    tick();
    check("nop", 32'(obs_ctl), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0)));
    tick();

    // Reset during S2 of XOR r1,r2 with two queued LOADs
    push(10'b0101_001_010);
    push(10'b0001_001_000);
    push(10'b0001_011_000);
    check("rx_s2", 32'(obs_ctl), 32'(mk(0, 0, 4'b0100, 0, 0, 1, 0, 0, 1, 2'b10, 0, 0)));
    check("rx_count", 32'(instr_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rx_ctl0", 32'(obs_ctl), 32'(idle_v));
    check("rx_count0", 32'(instr_count), 32'd0);
    check("rx_busy0", 32'(busy), 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_ctl%0d", i), 32'(obs_ctl), 32'(idle_v));
      check($sformatf("post_rst_busy%0d", i), 32'(busy), 32'd0);
    end
    check("post_rst_count", 32'(instr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
